gc_flush_sequencer: RTL and testbench
=====================================

GC_FLUSH_SEQUENCER -- requirements
Module: gc_flush_sequencer

Interface
REQ-001 Param NUM_SRC, 4, number of exception sources.
REQ-002 Param ID_W, 3, instruction-ID width.
REQ-003 Param INIT_DEPTH, 64, cycles of post-reset clear (power of 2).
REQ-004 Param TLB_DEPTH, 32, cycles of TLB clear (power of 2, <= INIT_DEPTH).
REQ-005 Ports: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
REQ-006 Request ports:
- req_valid  in  1  gc-class instruction issued.
- req_op  in  2  0=IFENCE, 1=MRET, 2=SRET, 3=SFENCE.
- req_pc_p4  in  32  PC+4 of the request.
REQ-007 Exception ports:
- exc_valid  in  NUM_SRC  per-source exception pending.
- exc_id  in  NUM_SRC*ID_W  per-source instruction ID.
- exc_code  in  NUM_SRC*5  per-source cause.
- exc_tval  in  NUM_SRC*32  per-source tval.
- exc_ack  out  NUM_SRC  one-hot acknowledge.
REQ-008 Status ports:
- oldest_id  in  ID_W  ID of the oldest instruction.
- post_issue_count  in  ID_W+1  instructions in flight.
- sq_empty  in  1  store queue empty.
- stores_pending  in  1  released stores not yet drained.
- irq_pending  in  1  interrupt pending.
- epc  in  32  return PC.
- trap_vector  in  32  trap target PC.
REQ-009 Cache-invalidate handshake:
- inv_req  out  1  I-cache invalidate request.
- inv_ack  in  1  invalidate complete.
REQ-010 Control outputs, 1 bit each: fetch_hold, issue_hold, retire_hold, wb_suppress, init_clear, tlb_flush, sq_flush, pc_override.
REQ-011 Other outputs:
- pc  out  32  override PC.
- trap_taken  out  1  trap entry pulse.
- irq_taken  out  1  interrupt entry pulse.
- mret  out  1  MRET pulse.
- sret  out  1  SRET pulse.
- trap_code  out  5  cause of the trap.
- trap_tval  out  32  tval of the trap.

Function
REQ-012 States RESET, INIT_CLEAR, IDLE, DRAIN, INVALIDATE, TLB_CLEAR, FLUSH, DISCARD shall exist; any other encoding -> RESET.
REQ-013 Exception selection: lowest index i with exc_valid[i] & exc_id[i]==oldest_id ("exc_hit"); exc_ack[i] asserted combinationally that cycle only.
REQ-014 Transitions:
- RESET->INIT_CLEAR.
- INIT_CLEAR->IDLE after INIT_DEPTH cycles.
- IDLE: exc_hit->FLUSH; else req_valid|irq_pending|any exc_valid->DRAIN.
- DRAIN: exc_hit->FLUSH; else irq_pending->FLUSH; else op latched & idle (post_issue_count==0 & sq_empty): IFENCE->INVALIDATE, SFENCE->TLB_CLEAR, MRET/SRET->FLUSH.
- INVALIDATE->FLUSH on inv_ack.
- TLB_CLEAR->FLUSH after TLB_DEPTH cycles.
- FLUSH->DISCARD (1 cycle).
- DISCARD->IDLE when post_issue_count==0 & !stores_pending.
REQ-015 Priority on simultaneous events: exception > interrupt > latched op; a latched op preempted by exception or interrupt shall be dropped.
REQ-016 req_op and req_pc_p4 shall be latched on req_valid; the latch shall clear on entry to FLUSH.
REQ-017 Holds and clears are registered from next_state (1-cycle latency):
- fetch_hold in {INIT_CLEAR, DRAIN, INVALIDATE, TLB_CLEAR, FLUSH}.
- issue_hold in all states except IDLE.
- wb_suppress in {INIT_CLEAR, DISCARD}.
- retire_hold in {FLUSH}.
- init_clear in {INIT_CLEAR}.
- tlb_flush in {INIT_CLEAR, TLB_CLEAR}.
REQ-018 sq_flush shall pulse 1 cycle on the DISCARD->IDLE transition.
REQ-019 pc_override shall pulse 1 cycle after next_state==FLUSH or after RESET->INIT_CLEAR. pc = trap_vector (trap/irq), req_pc_p4 (IFENCE/SFENCE), or epc (ret).
REQ-020 trap_taken, irq_taken, mret and sret shall be combinational with next_state==FLUSH, mutually exclusive. trap_code/trap_tval shall be registered with trap_taken.
REQ-021 inv_req shall be high for every cycle in INVALIDATE and drop the cycle after inv_ack; inv_ack outside INVALIDATE shall be ignored.
REQ-022 State counter: width clog2(INIT_DEPTH)+1; zeroed on entry to IDLE; no wrap.

Reset
REQ-023 While rst==0: state=RESET, latched op cleared, counter 0, all outputs 0 except issue_hold=1 and fetch_hold=1. Reset mid-operation shall abandon any handshake, with inv_req low next cycle.

Configuration
REQ-024 With GC_DEBUG_HALT_EN defined:
- add port halt_req in 1, halted out 1, and state HALTED.
- DRAIN+idle+halt_req -> HALTED (below exception/irq priority).
- HALTED holds fetch and issue and asserts halted.
- HALTED->IDLE on !halt_req, with no PC override.
REQ-025 Without GC_DEBUG_HALT_EN: the ports and state shall be absent.

Structure
REQ-026 gc_op_t enum, the state enum and the cause width belong in the shared types package.
REQ-027 One sub-module, gc_exception_select (REQ-013 priority picker), is natural.

Verification
REQ-028 Reset release -> pc_override pulse at cycle 1; init_clear high 64 cycles; then IDLE with issue_hold=0.
REQ-029 exc_valid[2], exc_id[2]==oldest_id=5, code=2 -> exc_ack=4'b0100; trap_taken; pc=trap_vector; trap_code=2.
REQ-030 IFENCE with req_pc_p4=0x104, count drains to 0, inv_ack after 7 cycles -> inv_req high 7 cycles; pc=0x104.
REQ-031 MRET and irq_pending together in DRAIN -> irq_taken=1, mret=0, pc=trap_vector.
REQ-032 SFENCE -> tlb_flush high 32 cycles; then FLUSH; sq_flush pulses once on exit from DISCARD.
REQ-033 rst asserted in INVALIDATE -> inv_req=0 and state RESET next cycle.

Source files
------------

// File: rtl/gc_flush_sequencer_pkg.sv
// Shared types for the gc-class flush sequencer: op codes, FSM states, flush causes.
// GC_DEBUG_HALT_EN adds the HALTED state used by the debug-halt feature.
package gc_flush_sequencer_pkg;

    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned XLEN    = 32;

    typedef enum logic [1:0] {
        OP_IFENCE = 2'd0,
        OP_MRET   = 2'd1,
        OP_SRET   = 2'd2,
        OP_SFENCE = 2'd3
    } gc_op_t;

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_INIT_CLEAR = 4'd1,
        ST_IDLE       = 4'd2,
        ST_DRAIN      = 4'd3,
        ST_INVALIDATE = 4'd4,
        ST_TLB_CLEAR  = 4'd5,
        ST_FLUSH      = 4'd6,
        ST_DISCARD    = 4'd7
`ifdef GC_DEBUG_HALT_EN
        , ST_HALTED   = 4'd8
`endif
    } gc_state_t;

    // Reason the sequencer is entering FLUSH; selects the override PC and pulses.
    typedef enum logic [2:0] {
        FK_NONE  = 3'd0,
        FK_TRAP  = 3'd1,
        FK_IRQ   = 3'd2,
        FK_MRET  = 3'd3,
        FK_SRET  = 3'd4,
        FK_FENCE = 3'd5
    } gc_flush_kind_t;

endpackage

// File: rtl/gc_flush_sequencer_exception_select.sv
// Priority picker: lowest-index exception source whose ID matches the oldest instruction.
module gc_exception_select #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_SRC-1:0]      i_exc_valid,
    input  logic [NUM_SRC*ID_W-1:0] i_exc_id,
    input  logic [ID_W-1:0]         i_oldest_id,
    output logic                    o_hit,
    output logic [NUM_SRC-1:0]      o_onehot
);

    always_comb begin
        o_hit    = 1'b0;
        o_onehot = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (i_exc_valid[i] && (i_exc_id[i*ID_W +: ID_W] == i_oldest_id)) begin
                o_hit    = 1'b1;
                o_onehot = NUM_SRC'(1) << i;
            end
        end
    end

endmodule

// File: rtl/gc_flush_sequencer.sv
// Sequences pipeline drain/flush for fences, returns, traps and interrupts.
// Optional debug halt (halt_req/halted, HALTED state) when GC_DEBUG_HALT_EN is defined.
module gc_flush_sequencer
    import gc_flush_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ID_W       = 3,
    parameter int unsigned INIT_DEPTH = 64,
    parameter int unsigned TLB_DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [1:0]                 req_op,
    input  logic [XLEN-1:0]            req_pc_p4,
    input  logic [NUM_SRC-1:0]         exc_valid,
    input  logic [NUM_SRC*ID_W-1:0]    exc_id,
    input  logic [NUM_SRC*CAUSE_W-1:0] exc_code,
    input  logic [NUM_SRC*XLEN-1:0]    exc_tval,
    output logic [NUM_SRC-1:0]         exc_ack,
    input  logic [ID_W-1:0]            oldest_id,
    input  logic [ID_W:0]              post_issue_count,
    input  logic                       sq_empty,
    input  logic                       stores_pending,
    input  logic                       irq_pending,
    input  logic [XLEN-1:0]            epc,
    input  logic [XLEN-1:0]            trap_vector,
    output logic                       inv_req,
    input  logic                       inv_ack,
`ifdef GC_DEBUG_HALT_EN
    input  logic                       halt_req,
    output logic                       halted,
`endif
    output logic                       fetch_hold,
    output logic                       issue_hold,
    output logic                       retire_hold,
    output logic                       wb_suppress,
    output logic                       init_clear,
    output logic                       tlb_flush,
    output logic                       sq_flush,
    output logic                       pc_override,
    output logic [XLEN-1:0]            pc,
    output logic                       trap_taken,
    output logic                       irq_taken,
    output logic                       mret,
    output logic                       sret,
    output logic [CAUSE_W-1:0]         trap_code,
    output logic [XLEN-1:0]            trap_tval
);

    localparam int unsigned CNT_W = $clog2(INIT_DEPTH) + 1;

    gc_state_t          r_state;
    gc_state_t          w_next;
    gc_flush_kind_t     w_kind;
    logic               r_op_vld;
    gc_op_t             r_op;
    logic [XLEN-1:0]    r_pc_p4;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_exc_hit;
    logic [NUM_SRC-1:0] w_exc_onehot;
    logic [CAUSE_W-1:0] w_sel_code;
    logic [XLEN-1:0]    w_sel_tval;
    logic [XLEN-1:0]    w_pc_nxt;
    logic               w_quiet;
    logic               w_fetch_hold;
    logic               w_pc_load;

    logic               r_fetch_hold, r_issue_hold, r_retire_hold, r_wb_suppress;
    logic               r_init_clear, r_tlb_flush, r_sq_flush, r_pc_override, r_inv_req;
    logic [XLEN-1:0]    r_pc;
    logic [CAUSE_W-1:0] r_trap_code;
    logic [XLEN-1:0]    r_trap_tval;
`ifdef GC_DEBUG_HALT_EN
    logic               r_halted;
`endif

    gc_exception_select #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_exc_sel (
        .i_exc_valid (exc_valid),
        .i_exc_id    (exc_id),
        .i_oldest_id (oldest_id),
        .o_hit       (w_exc_hit),
        .o_onehot    (w_exc_onehot)
    );

    // Payload of the selected exception source.
    always_comb begin
        w_sel_code = '0;
        w_sel_tval = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_exc_onehot[i]) begin
                w_sel_code = exc_code[i*CAUSE_W +: CAUSE_W];
                w_sel_tval = exc_tval[i*XLEN +: XLEN];
            end
        end
    end

    assign w_quiet = (post_issue_count == '0) && sq_empty;

    always_comb begin
        w_next = r_state;
        w_kind = FK_NONE;
        case (r_state)
            ST_RESET:      w_next = ST_INIT_CLEAR;
            ST_INIT_CLEAR: if (r_cnt == CNT_W'(INIT_DEPTH - 1)) w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_exc_hit) begin
                    w_next = ST_FLUSH;
                    w_kind = FK_TRAP;
                end else if (req_valid || irq_pending || (|exc_valid)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_exc_hit) begin
                    w_next = ST_FLUSH;
                    w_kind = FK_TRAP;
                end else if (irq_pending) begin
                    w_next = ST_FLUSH;
                    w_kind = FK_IRQ;
                end else if (w_quiet && r_op_vld) begin
                    case (r_op)
                        OP_IFENCE: w_next = ST_INVALIDATE;
                        OP_SFENCE: w_next = ST_TLB_CLEAR;
                        OP_MRET: begin
                            w_next = ST_FLUSH;
                            w_kind = FK_MRET;
                        end
                        default: begin
                            w_next = ST_FLUSH;
                            w_kind = FK_SRET;
                        end
                    endcase
`ifdef GC_DEBUG_HALT_EN
                end else if (w_quiet && halt_req) begin
                    w_next = ST_HALTED;
`endif
                end
            end
            ST_INVALIDATE: begin
                if (inv_ack) begin
                    w_next = ST_FLUSH;
                    w_kind = FK_FENCE;
                end
            end
            ST_TLB_CLEAR: begin
                if (r_cnt == CNT_W'(TLB_DEPTH - 1)) begin
                    w_next = ST_FLUSH;
                    w_kind = FK_FENCE;
                end
            end
            ST_FLUSH:   w_next = ST_DISCARD;
            ST_DISCARD: if ((post_issue_count == '0) && !stores_pending) w_next = ST_IDLE;
`ifdef GC_DEBUG_HALT_EN
            ST_HALTED:  if (!halt_req) w_next = ST_IDLE;
`endif
            default:    w_next = ST_RESET;
        endcase
        if (!rst) begin
            w_next = ST_RESET;
            w_kind = FK_NONE;
        end
    end

    always_comb begin
        w_pc_nxt = trap_vector;
        case (w_kind)
            FK_MRET, FK_SRET: w_pc_nxt = epc;
            FK_FENCE:         w_pc_nxt = r_pc_p4;
            default:          w_pc_nxt = trap_vector;
        endcase
    end

    assign w_pc_load = (w_next == ST_FLUSH) || ((r_state == ST_RESET) && (w_next == ST_INIT_CLEAR));

    always_comb begin
        w_fetch_hold = w_next inside {ST_INIT_CLEAR, ST_DRAIN, ST_INVALIDATE, ST_TLB_CLEAR, ST_FLUSH};
`ifdef GC_DEBUG_HALT_EN
        if (w_next == ST_HALTED) w_fetch_hold = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_RESET;
            r_op_vld      <= 1'b0;
            r_op          <= OP_IFENCE;
            r_pc_p4       <= '0;
            r_cnt         <= '0;
            r_fetch_hold  <= 1'b1;
            r_issue_hold  <= 1'b1;
            r_retire_hold <= 1'b0;
            r_wb_suppress <= 1'b0;
            r_init_clear  <= 1'b0;
            r_tlb_flush   <= 1'b0;
            r_sq_flush    <= 1'b0;
            r_pc_override <= 1'b0;
            r_inv_req     <= 1'b0;
            r_pc          <= '0;
            r_trap_code   <= '0;
            r_trap_tval   <= '0;
`ifdef GC_DEBUG_HALT_EN
            r_halted      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // Entering FLUSH consumes (or drops, if preempted) the latched request.
            if (w_next == ST_FLUSH) begin
                r_op_vld <= 1'b0;
            end else if (req_valid && (r_state inside {ST_IDLE, ST_DRAIN})) begin
                r_op_vld <= 1'b1;
                r_op     <= gc_op_t'(req_op);
                r_pc_p4  <= req_pc_p4;
            end
            if (w_next == ST_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state inside {ST_INIT_CLEAR, ST_TLB_CLEAR}) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_fetch_hold  <= w_fetch_hold;
            r_issue_hold  <= (w_next != ST_IDLE);
            r_retire_hold <= (w_next == ST_FLUSH);
            r_wb_suppress <= w_next inside {ST_INIT_CLEAR, ST_DISCARD};
            r_init_clear  <= (w_next == ST_INIT_CLEAR);
            r_tlb_flush   <= w_next inside {ST_INIT_CLEAR, ST_TLB_CLEAR};
            r_sq_flush    <= (r_state == ST_DISCARD) && (w_next == ST_IDLE);
            r_inv_req     <= (w_next == ST_INVALIDATE);
            r_pc_override <= w_pc_load;
            if (w_pc_load) r_pc <= w_pc_nxt;
            if (w_kind == FK_TRAP) begin
                r_trap_code <= w_sel_code;
                r_trap_tval <= w_sel_tval;
            end
`ifdef GC_DEBUG_HALT_EN
            r_halted      <= (w_next == ST_HALTED);
`endif
        end
    end

    assign exc_ack     = (w_kind == FK_TRAP) ? w_exc_onehot : '0;
    assign trap_taken  = (w_kind == FK_TRAP);
    assign irq_taken   = (w_kind == FK_IRQ);
    assign mret        = (w_kind == FK_MRET);
    assign sret        = (w_kind == FK_SRET);
    assign fetch_hold  = r_fetch_hold;
    assign issue_hold  = r_issue_hold;
    assign retire_hold = r_retire_hold;
    assign wb_suppress = r_wb_suppress;
    assign init_clear  = r_init_clear;
    assign tlb_flush   = r_tlb_flush;
    assign sq_flush    = r_sq_flush;
    assign pc_override = r_pc_override;
    assign inv_req     = r_inv_req;
    assign pc          = r_pc;
    assign trap_code   = r_trap_code;
    assign trap_tval   = r_trap_tval;
`ifdef GC_DEBUG_HALT_EN
    assign halted      = r_halted;
`endif

endmodule

// File: tb/tb_gc_flush_sequencer.sv
// Directed bench for gc_flush_sequencer: init clear, trap, IFENCE, irq-vs-MRET, SRET, SFENCE, reset abort.
module tb_gc_flush_sequencer;

    localparam logic [31:0] TVEC = 32'h8000_0000;
    localparam logic [31:0] EPC  = 32'h0000_2000;

    logic        clk, rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_pc_p4;
    logic [3:0]  exc_valid;
    logic [11:0] exc_id;
    logic [19:0] exc_code;
    logic [127:0] exc_tval;
    logic [3:0]  exc_ack;
    logic [2:0]  oldest_id;
    logic [3:0]  post_issue_count;
    logic        sq_empty, stores_pending, irq_pending;
    logic [31:0] epc, trap_vector;
    logic        inv_req, inv_ack;
    logic        fetch_hold, issue_hold, retire_hold, wb_suppress;
    logic        init_clear, tlb_flush, sq_flush, pc_override;
    logic [31:0] pc;
    logic        trap_taken, irq_taken, mret, sret;
    logic [4:0]  trap_code;
    logic [31:0] trap_tval;
`ifdef GC_DEBUG_HALT_EN
    logic        halt_req, halted;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gc_flush_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_pc_p4(req_pc_p4),
        .exc_valid(exc_valid), .exc_id(exc_id), .exc_code(exc_code), .exc_tval(exc_tval),
        .exc_ack(exc_ack), .oldest_id(oldest_id), .post_issue_count(post_issue_count),
        .sq_empty(sq_empty), .stores_pending(stores_pending), .irq_pending(irq_pending),
        .epc(epc), .trap_vector(trap_vector), .inv_req(inv_req), .inv_ack(inv_ack),
`ifdef GC_DEBUG_HALT_EN
        .halt_req(halt_req), .halted(halted),
`endif
        .fetch_hold(fetch_hold), .issue_hold(issue_hold), .retire_hold(retire_hold),
        .wb_suppress(wb_suppress), .init_clear(init_clear), .tlb_flush(tlb_flush),
        .sq_flush(sq_flush), .pc_override(pc_override), .pc(pc),
        .trap_taken(trap_taken), .irq_taken(irq_taken), .mret(mret), .sret(sret),
        .trap_code(trap_code), .trap_tval(trap_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ic_cnt, po_cnt, inv_cnt, tlb_cnt, sq_cnt, rh_cnt;
        logic [31:0] pc_seen;

        rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_pc_p4 = '0;
        exc_valid = '0; exc_id = '0; exc_code = '0; exc_tval = '0;
        oldest_id = '0; post_issue_count = '0; sq_empty = 1'b1;
        stores_pending = 1'b0; irq_pending = 1'b0; epc = EPC; trap_vector = TVEC;
        inv_ack = 1'b0;
`ifdef GC_DEBUG_HALT_EN
        halt_req = 1'b0;
`endif

        // Held in reset.
        repeat (3) tick();
        chk("rst_issue_hold", 64'(issue_hold), 64'd1);
        chk("rst_fetch_hold", 64'(fetch_hold), 64'd1);
        chk("rst_pc_override", 64'(pc_override), 64'd0);
        chk("rst_init_clear", 64'(init_clear), 64'd0);
        chk("rst_inv_req", 64'(inv_req), 64'd0);

        // Release: pc_override at cycle 1, init_clear for 64 cycles, then IDLE.
        rst = 1'b1;
        tick();
        chk("rel_pc_override", 64'(pc_override), 64'd1);
        ic_cnt = 0; po_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (init_clear)  ic_cnt++;
            if (pc_override) po_cnt++;
            tick();
        end
        chk("init_clear_cycles", 64'(ic_cnt), 64'd64);
        chk("init_po_pulses", 64'(po_cnt), 64'd1);
        chk("idle_issue_hold", 64'(issue_hold), 64'd0);
        chk("idle_fetch_hold", 64'(fetch_hold), 64'd0);
        chk("idle_tlb_flush", 64'(tlb_flush), 64'd0);

        // Trap: sources 2 and 3 match oldest_id 5, source 0 does not; lowest matching wins.
        oldest_id = 3'd5;
        exc_id    = {3'd5, 3'd5, 3'd0, 3'd1};
        exc_code  = {5'd7, 5'd2, 5'd0, 5'd9};
        exc_tval  = {32'h3333_3333, 32'hDEAD_0002, 32'h0, 32'h9999_9999};
        exc_valid = 4'b1101;
        #1;
        chk("trap_exc_ack", 64'(exc_ack), 64'h4);
        chk("trap_taken", 64'(trap_taken), 64'd1);
        chk("trap_irq_taken", 64'(irq_taken), 64'd0);
        tick();
        exc_valid = '0;
        post_issue_count = 4'd2;
        #1;
        chk("trap_pc_override", 64'(pc_override), 64'd1);
        chk("trap_pc", 64'(pc), 64'(TVEC));
        chk("trap_code", 64'(trap_code), 64'd2);
        chk("trap_tval", 64'(trap_tval), 64'hDEAD_0002);
        chk("trap_retire_hold", 64'(retire_hold), 64'd1);
        chk("trap_exc_ack_gone", 64'(exc_ack), 64'd0);
        tick();
        chk("discard_wb_suppress", 64'(wb_suppress), 64'd1);
        chk("discard_po_low", 64'(pc_override), 64'd0);
        tick();
        chk("discard_wait", 64'(wb_suppress), 64'd1);
        chk("discard_no_sq_flush", 64'(sq_flush), 64'd0);
        post_issue_count = 4'd0;
        tick();
        chk("trap_sq_flush", 64'(sq_flush), 64'd1);
        chk("trap_back_idle", 64'(issue_hold), 64'd0);
        tick();
        chk("trap_sq_flush_pulse", 64'(sq_flush), 64'd0);

        // IFENCE: drain, invalidate with inv_ack after 7 cycles, flush to pc+4.
        req_valid = 1'b1; req_op = 2'd0; req_pc_p4 = 32'h104; post_issue_count = 4'd3;
        tick();
        req_valid = 1'b0;
        chk("ifence_drain_fetch_hold", 64'(fetch_hold), 64'd1);
        chk("ifence_drain_no_inv", 64'(inv_req), 64'd0);
        tick();
        post_issue_count = 4'd0;
        tick();
        inv_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            if (inv_req) inv_cnt++;
            if (k == 7) begin
                inv_ack = 1'b1;
                #1;
                chk("ifence_no_trap", 64'(trap_taken), 64'd0);
                chk("ifence_no_mret", 64'(mret), 64'd0);
            end
            tick();
        end
        inv_ack = 1'b0;
        chk("ifence_inv_cycles", 64'(inv_cnt), 64'd7);
        chk("ifence_inv_drop", 64'(inv_req), 64'd0);
        chk("ifence_pc_override", 64'(pc_override), 64'd1);
        chk("ifence_pc", 64'(pc), 64'h104);
        tick();
        tick();
        chk("ifence_back_idle", 64'(issue_hold), 64'd0);

        // MRET latched, irq arrives in DRAIN: interrupt wins and MRET is dropped.
        req_valid = 1'b1; req_op = 2'd1; post_issue_count = 4'd1;
        tick();
        req_valid = 1'b0; irq_pending = 1'b1; post_issue_count = 4'd0;
        #1;
        chk("irq_taken", 64'(irq_taken), 64'd1);
        chk("irq_mret_low", 64'(mret), 64'd0);
        chk("irq_trap_low", 64'(trap_taken), 64'd0);
        tick();
        irq_pending = 1'b0;
        chk("irq_pc", 64'(pc), 64'(TVEC));
        chk("irq_pc_override", 64'(pc_override), 64'd1);
        tick();
        tick();
        chk("irq_back_idle", 64'(issue_hold), 64'd0);

        // Non-oldest exception parks in DRAIN; the dropped MRET must not fire.
        oldest_id = 3'd5; exc_valid = 4'b0001;
        tick();
        tick();
        chk("drop_no_mret", 64'(mret), 64'd0);
        chk("drop_no_po", 64'(pc_override), 64'd0);
        chk("drop_in_drain", 64'(fetch_hold), 64'd1);
        oldest_id = 3'd1;
        #1;
        chk("drain_trap_taken", 64'(trap_taken), 64'd1);
        chk("drain_exc_ack", 64'(exc_ack), 64'h1);
        tick();
        exc_valid = '0;
        chk("drain_trap_code", 64'(trap_code), 64'd9);
        chk("drain_trap_tval", 64'(trap_tval), 64'h9999_9999);
        tick();
        tick();
        chk("drain_back_idle", 64'(issue_hold), 64'd0);

        // SRET: returns to epc.
        req_valid = 1'b1; req_op = 2'd2;
        tick();
        req_valid = 1'b0;
        #1;
        chk("sret_pulse", 64'(sret), 64'd1);
        chk("sret_no_mret", 64'(mret), 64'd0);
        tick();
        chk("sret_pc", 64'(pc), 64'(EPC));
        tick();
        tick();

        // SFENCE: 32 cycles of tlb_flush, flush to pc+4, single sq_flush on DISCARD exit.
        req_valid = 1'b1; req_op = 2'd3; req_pc_p4 = 32'h200;
        tick();
        req_valid = 1'b0; stores_pending = 1'b1;
        tick();
        tlb_cnt = 0; sq_cnt = 0; po_cnt = 0; rh_cnt = 0; pc_seen = '0;
        for (int k = 0; k < 45; k++) begin
            if (tlb_flush)   tlb_cnt++;
            if (sq_flush)    sq_cnt++;
            if (retire_hold) rh_cnt++;
            if (pc_override) begin
                po_cnt++;
                pc_seen = pc;
            end
            if (k == 38) stores_pending = 1'b0;
            tick();
        end
        chk("sfence_tlb_cycles", 64'(tlb_cnt), 64'd32);
        chk("sfence_sq_flush_pulses", 64'(sq_cnt), 64'd1);
        chk("sfence_po_pulses", 64'(po_cnt), 64'd1);
        chk("sfence_retire_cycles", 64'(rh_cnt), 64'd1);
        chk("sfence_pc", 64'(pc_seen), 64'h200);
        chk("sfence_back_idle", 64'(issue_hold), 64'd0);

        // Reset asserted while INVALIDATE is waiting: handshake abandoned.
        req_valid = 1'b1; req_op = 2'd0; req_pc_p4 = 32'h300;
        tick();
        req_valid = 1'b0;
        tick();
        chk("abort_inv_req_high", 64'(inv_req), 64'd1);
        rst = 1'b0;
        tick();
        chk("abort_inv_req_low", 64'(inv_req), 64'd0);
        chk("abort_issue_hold", 64'(issue_hold), 64'd1);
        chk("abort_fetch_hold", 64'(fetch_hold), 64'd1);
        chk("abort_po_low", 64'(pc_override), 64'd0);
        rst = 1'b1;
        tick();
        chk("abort_restart_po", 64'(pc_override), 64'd1);
        chk("abort_restart_init", 64'(init_clear), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
